// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared types and saturating step helper for the PWM duty front-panel controller.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {NONE, INC_F, INC_C, DEC_F, DEC_C, CONFLICT} cmd_t;
  typedef enum logic [2:0] {IDLE, DEB, FIRE, HOLD, REPEAT} state_t;

  // One extra bit of headroom so an increment near the top cannot wrap before clamping.
  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] cur,
                                                 input logic up,
                                                 input logic [DUTY_W:0] step,
                                                 input logic [DUTY_W:0] lim);
    logic [DUTY_W:0] wide;
    wide = {1'b0, cur};
    if (up) begin
      wide = wide + step;
      if (wide > lim) wide = lim;
    end else begin
      wide = (wide < step) ? '0 : wide - step;
    end
    return wide[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button, period and duty signals between the front panel/PWM datapath and the controller.
interface pwm_duty_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic              inc_n;
  logic              inc1_n;
  logic              dec_n;
  logic              dec1_n;
  logic              period_end;
  logic [DUTY_W-1:0] duty;
  logic              duty_load;
  logic [DUTY_W-1:0] target_duty;

  modport master (
    output inc_n, inc1_n, dec_n, dec1_n, period_end,
    input  duty, duty_load, target_duty
  );

  modport slave (
    input  inc_n, inc1_n, dec_n, dec1_n, period_end,
    output duty, duty_load, target_duty
  );

endinterface

// File: rtl/pwm_duty_ctrl_btn_sync.sv
// Two-flop synchroniser for the four active-low buttons; output is active-high "pressed".
module btn_sync (
  input  logic       clkin,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic [3:0] btn
);

  logic [3:0] s1;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1  <= '0;
      btn <= '0;
    end else begin
      s1  <= ~btn_n;
      btn <= s1;
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Debounced, auto-repeating duty target with period-boundary apply to the PWM comparator.
// state  | meaning
// IDLE   | no command held; latch a valid command
// DEB    | command must stay stable for DEBOUNCE_CYC cycles
// FIRE   | one cycle: step the target by the latched command
// HOLD   | delay after the first fire before auto-repeat
// REPEAT | auto-repeat interval between fires
module pwm_duty_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DLY   = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int FINE_STEP    = 1,
  parameter int COARSE_STEP  = 10,
  parameter int DUTY_MAX     = 100,
  parameter int DUTY_RST     = 50
) (
  input  logic            clkin,
  input  logic            reset,
  pwm_duty_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DLY > DEBOUNCE_CYC)
                         ? ((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE)
                         : ((DEBOUNCE_CYC > REPEAT_RATE) ? DEBOUNCE_CYC : REPEAT_RATE);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int WW    = DUTY_W + 1;

  localparam logic [CNT_W-1:0]  DEB_TC  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]  DLY_TC  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]  RATE_TC = CNT_W'(REPEAT_RATE - 1);
  localparam logic [WW-1:0]     FSTEP   = WW'(FINE_STEP);
  localparam logic [WW-1:0]     CSTEP   = WW'(COARSE_STEP);
  localparam logic [WW-1:0]     LIM     = WW'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] RST_V   = DUTY_W'(DUTY_RST);

  logic [3:0]        btn;
  cmd_t              cmd, lcmd, lcmd_nx;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              rep, rep_nx, fire;
  logic [DUTY_W-1:0] target, duty, tgt_fire, tgt_nx, duty_nx;
  logic              duty_load, pending, pending_nx, apply;
  logic              up;
  logic [WW-1:0]     step;

  // btn bit order: {dec1, dec, inc1, inc}
  btn_sync u_sync (
    .clkin (clkin),
    .reset (reset),
    .btn_n ({bus.dec1_n, bus.dec_n, bus.inc1_n, bus.inc_n}),
    .btn   (btn)
  );

  always_comb begin
    cmd = NONE;
    if ((btn[0] | btn[1]) && (btn[2] | btn[3])) cmd = CONFLICT;
    else if (btn[1])                            cmd = INC_C;
    else if (btn[0])                            cmd = INC_F;
    else if (btn[3])                            cmd = DEC_C;
    else if (btn[2])                            cmd = DEC_F;
  end

  always_comb begin
    state_nx = state;
    lcmd_nx  = lcmd;
    cnt_nx   = cnt + 1'b1;
    rep_nx   = rep;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (cmd != NONE && cmd != CONFLICT) begin
          lcmd_nx  = cmd;
          state_nx = DEB;
        end
      end
      DEB: begin
        if (cmd != lcmd) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          state_nx = FIRE;
          cnt_nx   = '0;
        end
      end
      FIRE: begin
        fire     = 1'b1;
        cnt_nx   = '0;
        rep_nx   = 1'b1;
        state_nx = rep ? REPEAT : HOLD;
      end
      HOLD, REPEAT: begin
        if (cmd != lcmd) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          rep_nx   = 1'b0;
        end else if (cnt == ((state == HOLD) ? DLY_TC : RATE_TC)) begin
          state_nx = FIRE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        rep_nx   = 1'b0;
      end
    endcase
  end

  // Apply uses the registered target, so a same-cycle FIRE waits for the next boundary.
  always_comb begin
    up         = (lcmd == INC_F) || (lcmd == INC_C);
    step       = ((lcmd == INC_C) || (lcmd == DEC_C)) ? CSTEP : FSTEP;
    tgt_fire   = sat_step(target, up, step, LIM);
    apply      = bus.period_end && pending;
    duty_nx    = apply ? target : duty;
    tgt_nx     = fire ? tgt_fire : target;
    pending_nx = pending;
    if (apply) pending_nx = 1'b0;
    if (fire && (tgt_fire != duty_nx)) pending_nx = 1'b1;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lcmd      <= NONE;
      cnt       <= '0;
      rep       <= 1'b0;
      target    <= RST_V;
      duty      <= RST_V;
      duty_load <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nx;
      lcmd      <= lcmd_nx;
      cnt       <= cnt_nx;
      rep       <= rep_nx;
      target    <= tgt_nx;
      duty      <= duty_nx;
      duty_load <= apply;
      pending   <= pending_nx;
    end
  end

  assign bus.duty        = duty;
  assign bus.duty_load   = duty_load;
  assign bus.target_duty = target;

endmodule
